// File: rtl/mesh_router_xy.sv
// Generic FIFO with a registered occupancy count.
// Latency: a pushed word appears at the head one cycle after the push.
// Backpressure: o_push_rdy is low whenever full, even if a pop happens that cycle.
module mr_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push_vld,
   output logic         o_push_rdy,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic         o_pop_vld,
   output logic [W-1:0] o_pop_dat
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_push_rdy = (r_cnt != (AW+1)'(DEPTH));
   assign o_pop_vld  = (r_cnt != '0);
   assign o_pop_dat  = r_mem[r_rd_ptr];
   assign w_push     = i_push_vld & o_push_rdy;
   assign w_pop      = i_pop & o_pop_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end
endmodule

// Five-port XY mesh router node; ROUTER_BAD_DEST_DROP_EN drops out-of-mesh packets and adds err_cnt.
// Latency: packet accepted at edge N is presented on out_valid for the transfer at edge N+2.
// Backpressure: out_ready low holds the output register, then fills FIFOs, then drops in_ready.
module mesh_router_xy #(
   parameter int WIDTH   = 57,
   parameter int DEPTH   = 4,
   parameter int COORD_W = 4,
   parameter int MESH_X  = 5,
   parameter int MESH_Y  = 3,
   parameter int MY_X    = 0,
   parameter int MY_Y    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4:0]         in_valid,
   output logic [4:0]         in_ready,
   input  logic [5*WIDTH-1:0] in_data,
   output logic [4:0]         out_valid,
   input  logic [4:0]         out_ready,
   output logic [5*WIDTH-1:0] out_data
`ifdef ROUTER_BAD_DEST_DROP_EN
   ,output logic [7:0]        err_cnt
`endif
);
   localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_PE = 3'd4;
   localparam logic [COORD_W-1:0] MY_XC = COORD_W'(MY_X);
   localparam logic [COORD_W-1:0] MY_YC = COORD_W'(MY_Y);

   if (MY_X >= MESH_X || MY_Y >= MESH_Y || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("mesh_router_xy: illegal parameter set");
   end

   logic [WIDTH-1:0] w_head [5];
   logic [2:0]       w_route [5];
   logic [2:0]       w_gnt_src [5];
   logic [4:0]       w_nemp;
   logic [4:0]       w_req;
   logic [4:0]       w_pop;
   logic [4:0]       w_gnt_pop;
   logic [4:0]       w_gnt_vld;
   logic [4:0]       r_out_vld;
   logic [WIDTH-1:0] r_out_dat [5];
   logic [2:0]       r_rr [5];

   for (genvar i = 0; i < 5; i++) begin : g_port
      mr_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_push_vld (in_valid[i]),
         .o_push_rdy (in_ready[i]),
         .i_push_dat (in_data[i*WIDTH +: WIDTH]),
         .i_pop      (w_pop[i]),
         .o_pop_vld  (w_nemp[i]),
         .o_pop_dat  (w_head[i])
      );
      assign out_data[i*WIDTH +: WIDTH] = r_out_dat[i];
   end

   // X is resolved fully before Y; the route looks only at the header.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_route[i] = P_PE;
         if (w_head[i][COORD_W-1:0] > MY_XC)                    w_route[i] = P_E;
         else if (w_head[i][COORD_W-1:0] < MY_XC)               w_route[i] = P_W;
         else if (w_head[i][2*COORD_W-1:COORD_W] > MY_YC)       w_route[i] = P_S;
         else if (w_head[i][2*COORD_W-1:COORD_W] < MY_YC)       w_route[i] = P_N;
      end
   end

`ifdef ROUTER_BAD_DEST_DROP_EN
   localparam logic [COORD_W:0] MESH_XC = (COORD_W+1)'(MESH_X);
   localparam logic [COORD_W:0] MESH_YC = (COORD_W+1)'(MESH_Y);

   logic [4:0] w_drop;
   logic [8:0] w_err_sum;
   logic [7:0] r_err_cnt;

   always_comb begin
      w_err_sum = {1'b0, r_err_cnt};
      for (int i = 0; i < 5; i++) begin
         w_drop[i] = w_nemp[i] & (({1'b0, w_head[i][COORD_W-1:0]} >= MESH_XC) |
                                  ({1'b0, w_head[i][2*COORD_W-1:COORD_W]} >= MESH_YC));
         if (w_drop[i]) w_err_sum = w_err_sum + 9'd1;
      end
   end

   assign w_req   = w_nemp & ~w_drop;
   assign w_pop   = w_gnt_pop | w_drop;
   assign err_cnt = r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err_cnt <= '0;
      else        r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
   end
`else
   assign w_req = w_nemp;
   assign w_pop = w_gnt_pop;
`endif

   // Each head requests exactly one output, so grants never collide on an input.
   always_comb begin
      int idx;
      idx       = 0;
      w_gnt_vld = '0;
      w_gnt_pop = '0;
      for (int o = 0; o < 5; o++) begin
         w_gnt_src[o] = '0;
         if (!r_out_vld[o] || out_ready[o]) begin
            for (int k = 0; k < 5; k++) begin
               idx = int'(r_rr[o]) + k;
               if (idx >= 5) idx = idx - 5;
               if (!w_gnt_vld[o] && w_req[idx] && w_route[idx] == 3'(o)) begin
                  w_gnt_vld[o]   = 1'b1;
                  w_gnt_src[o]   = 3'(idx);
                  w_gnt_pop[idx] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= '0;
         for (int o = 0; o < 5; o++) begin
            r_out_dat[o] <= '0;
            r_rr[o]      <= '0;
         end
      end else begin
         for (int o = 0; o < 5; o++) begin
            if (w_gnt_vld[o]) begin
               r_out_vld[o] <= 1'b1;
               r_out_dat[o] <= w_head[w_gnt_src[o]];
               r_rr[o]      <= (w_gnt_src[o] == 3'd4) ? 3'd0 : w_gnt_src[o] + 3'd1;
            end else if (out_ready[o]) begin
               r_out_vld[o] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_out_vld;
endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy at node (2,1) of a 5x3 mesh.
module tb_mesh_router_xy;
   localparam int W = 57;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [4:0]     in_valid;
   logic [4:0]     in_ready;
   logic [5*W-1:0] in_data;
   logic [4:0]     out_valid;
   logic [4:0]     out_ready;
   logic [5*W-1:0] out_data;
`ifdef ROUTER_BAD_DEST_DROP_EN
   logic [7:0]     err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mesh_router_xy #(.MY_X(2), .MY_Y(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef ROUTER_BAD_DEST_DROP_EN
      ,.err_cnt  (err_cnt)
`endif
   );

   function automatic logic [W-1:0] pkt(input int tag, input int dx, input int dy);
      logic [W-1:0] p;
      p        = '0;
      p[3:0]   = dx[3:0];
      p[7:4]   = dy[3:0];
      p[56:8]  = {17'h15A5A, 32'(tag)};
      return p;
   endfunction

   function automatic logic [W-1:0] outp(input int o);
      return out_data[o*W +: W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int i, input logic [W-1:0] p);
      in_data[i*W +: W] = p;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      step();
      in_valid  = '0;
      out_ready = 5'b11111;
      rst_n     = 1'b0;
      #2;
      rst_n     = 1'b1;
      step();
   endtask

   initial begin
      logic [4:0] rdy;
      logic [4:0] seen;
      int nk, wk, acc, e;

      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 5'b11111;
      #12;
      chk("rst_out_valid", out_valid, 5'b00000);
      chk("rst_in_ready", in_ready, 5'b11111);
      chk("rst_out_data", out_data[63:0], 64'd0);
      rst_n = 1'b1;
      step();

      // Single PE packet eastward: valid is up for the transfer at edge 2.
      set_in(4, pkt(1, 4, 1));
      in_valid = 5'b10000;
      step();
      in_valid = '0;
      chk("t1_vld_after_e0", out_valid, 5'b00000);
      chk("t1_rdy_after_e0", in_ready, 5'b11111);
      step();
      chk("t1_vld_at_e2", out_valid, 5'b00100);
      chk("t1_dat_at_e2", outp(2), pkt(1, 4, 1));
      step();
      chk("t1_vld_drained", out_valid, 5'b00000);
      do_reset();

      // N and W both to PE every cycle: output alternates N,W,N,W...
      nk = 0;
      wk = 0;
      in_valid = 5'b01001;
      for (int cyc = 0; cyc < 10; cyc++) begin
         set_in(0, pkt(100 + nk, 2, 1));
         set_in(3, pkt(200 + wk, 2, 1));
         rdy = in_ready;
         step();
         if (rdy[0]) nk++;
         if (rdy[3]) wk++;
         if (cyc >= 1) begin
            e = cyc - 1;
            chk("t2_pe_vld", {4'd0, out_valid[4]}, 5'd1);
            chk("t2_pe_dat", outp(4), (e % 2 == 0) ? pkt(100 + e / 2, 2, 1) : pkt(200 + e / 2, 2, 1));
         end
      end
      in_valid = '0;
      do_reset();

      // Backpressure on E: one held in output register, four in FIFO.
      out_ready = 5'b11011;
      acc = 0;
      in_valid = 5'b10000;
      for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
         set_in(4, pkt(300 + acc, 4, 1));
         rdy = in_ready;
         step();
         if (rdy[4]) acc++;
      end
      chk("t3_accepts", acc, 5);
      chk("t3_in_ready_full", in_ready, 5'b01111);
      set_in(4, pkt(305, 4, 1));
      step();
      step();
      step();
      chk("t3_in_ready_held", in_ready, 5'b01111);
      chk("t3_out_held_vld", out_valid, 5'b00100);
      chk("t3_out_held_dat", outp(2), pkt(300, 4, 1));
      out_ready = 5'b11111;
      for (int k = 1; k <= 5; k++) begin
         rdy = in_ready;
         step();
         if (rdy[4] && in_valid[4]) in_valid = '0;
         chk("t3_drain_vld", out_valid, 5'b00100);
         chk("t3_drain_dat", outp(2), pkt(300 + k, 4, 1));
      end
      step();
      chk("t3_empty", out_valid, 5'b00000);
      do_reset();

      // All five inputs to five distinct outputs in parallel.
      set_in(0, pkt(400, 2, 1));
      set_in(1, pkt(401, 2, 0));
      set_in(2, pkt(402, 0, 1));
      set_in(3, pkt(403, 4, 1));
      set_in(4, pkt(404, 2, 2));
      in_valid = 5'b11111;
      step();
      in_valid = '0;
      chk("t4_vld_after_e0", out_valid, 5'b00000);
      step();
      chk("t4_all_vld", out_valid, 5'b11111);
      chk("t4_dat_pe", outp(4), pkt(400, 2, 1));
      chk("t4_dat_n", outp(0), pkt(401, 2, 0));
      chk("t4_dat_w", outp(3), pkt(402, 0, 1));
      chk("t4_dat_e", outp(2), pkt(403, 4, 1));
      chk("t4_dat_s", outp(1), pkt(404, 2, 2));
      do_reset();

      // Asynchronous reset while three packets are buffered.
      out_ready = 5'b00000;
      in_valid = 5'b10000;
      for (int k = 0; k < 3; k++) begin
         set_in(4, pkt(500 + k, 4, 1));
         step();
      end
      in_valid = '0;
      chk("t5_buffered_vld", out_valid, 5'b00100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_vld", out_valid, 5'b00000);
      chk("t5_rst_rdy", in_ready, 5'b11111);
      chk("t5_rst_dat", out_data[63:0], 64'd0);
      #2;
      rst_n = 1'b1;
      out_ready = 5'b11111;
      seen = '0;
      for (int k = 0; k < 6; k++) begin
         step();
         seen = seen | out_valid;
      end
      chk("t5_no_stale", seen, 5'b00000);
      do_reset();

`ifdef ROUTER_BAD_DEST_DROP_EN
      // Out-of-mesh destination (7,0) from N and E is dropped and counted.
      set_in(0, pkt(600, 7, 0));
      set_in(2, pkt(601, 7, 0));
      in_valid = 5'b00101;
      step();
      in_valid = '0;
      chk("t6_err_before_drop", err_cnt, 8'd0);
      step();
      chk("t6_no_vld", out_valid, 5'b00000);
      chk("t6_err_2", err_cnt, 8'd2);
      seen = '0;
      set_in(0, pkt(602, 7, 0));
      in_valid = 5'b00001;
      for (int k = 0; k < 10; k++) begin
         step();
         seen = seen | out_valid;
      end
      in_valid = '0;
      step();
      chk("t6_err_12", err_cnt, 8'd12);
      in_valid = 5'b00001;
      for (int k = 0; k < 288; k++) begin
         step();
         seen = seen | out_valid;
      end
      in_valid = '0;
      step();
      chk("t6_err_sat", err_cnt, 8'd255);
      chk("t6_never_vld", seen, 5'b00000);
`else
      // Without drop checking, (7,0) is routed east like any dest_x > 2.
      set_in(0, pkt(600, 7, 0));
      in_valid = 5'b00001;
      step();
      in_valid = '0;
      step();
      chk("t6_bad_dest_vld", out_valid, 5'b00100);
      chk("t6_bad_dest_dat", outp(2), pkt(600, 7, 0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
